// File: rtl/mapping_ctrl_pkg.sv
// Shared constants and types for the 16-channel to 8-lane pixel remapper.
package mapping_ctrl_pkg;

  localparam int unsigned CH_NUM   = 16;
  localparam int unsigned LANE_NUM = 8;
  localparam int unsigned WORD_W   = 12;

  typedef logic [WORD_W-1:0] word_t;

  // Line phase: capture takes the even words, replay emits the held odd words
  typedef enum logic {
    PH_CAPTURE = 1'b0,
    PH_REPLAY  = 1'b1
  } phase_e;

  typedef struct packed {
    word_t even;
    word_t odd;
  } ch_pair_t;

endpackage

// File: rtl/mapping_lane.sv
// One output lane: emits the even word on capture, then the held odd word on replay.
module mapping_lane
  import mapping_ctrl_pkg::*;
(
  input  logic     clk_rxg,
  input  logic     rst_rx_n,
  input  logic     lvals_map,
  input  phase_e   phase,
  input  ch_pair_t pair,
  output word_t    datapar_out
);

  word_t hold_q;
  word_t hold_d;
  word_t out_d;

  // Blank forces the lane to zero but leaves the hold register untouched
  always_comb begin
    hold_d = hold_q;
    out_d  = '0;
    if (lvals_map) begin
      if (phase == PH_CAPTURE) begin
        out_d  = pair.even;
        hold_d = pair.odd;
      end else begin
        out_d  = hold_q;
      end
    end
  end

  always_ff @(posedge clk_rxg or negedge rst_rx_n) begin
    if (!rst_rx_n) begin
      hold_q      <= '0;
      datapar_out <= '0;
    end else begin
      hold_q      <= hold_d;
      datapar_out <= out_d;
    end
  end

endmodule

// File: rtl/mapping_ctrl.sv
// Remaps 16 trained channel words onto 8 pixel lanes over two cycles, even channels first.
module mapping_ctrl
  import mapping_ctrl_pkg::*;
(
  input  logic              clk_rxg,
  input  logic              rst_rx_n,
  input  logic [WORD_W-1:0] data_trained0,
  input  logic [WORD_W-1:0] data_trained1,
  input  logic [WORD_W-1:0] data_trained2,
  input  logic [WORD_W-1:0] data_trained3,
  input  logic [WORD_W-1:0] data_trained4,
  input  logic [WORD_W-1:0] data_trained5,
  input  logic [WORD_W-1:0] data_trained6,
  input  logic [WORD_W-1:0] data_trained7,
  input  logic [WORD_W-1:0] data_trained8,
  input  logic [WORD_W-1:0] data_trained9,
  input  logic [WORD_W-1:0] data_trained10,
  input  logic [WORD_W-1:0] data_trained11,
  input  logic [WORD_W-1:0] data_trained12,
  input  logic [WORD_W-1:0] data_trained13,
  input  logic [WORD_W-1:0] data_trained14,
  input  logic [WORD_W-1:0] data_trained15,
  input  logic              fvals_map,
  input  logic              lvals_map,
  output logic [WORD_W-1:0] datapar_out0,
  output logic [WORD_W-1:0] datapar_out1,
  output logic [WORD_W-1:0] datapar_out2,
  output logic [WORD_W-1:0] datapar_out3,
  output logic [WORD_W-1:0] datapar_out4,
  output logic [WORD_W-1:0] datapar_out5,
  output logic [WORD_W-1:0] datapar_out6,
  output logic [WORD_W-1:0] datapar_out7,
  output logic              fvals,
  output logic              lvals
);

  word_t    data_trained [CH_NUM];
  word_t    lane_out     [LANE_NUM];
  ch_pair_t lane_pair    [LANE_NUM];
  phase_e   phase_q;
  phase_e   phase_d;

  assign data_trained[0]  = data_trained0;
  assign data_trained[1]  = data_trained1;
  assign data_trained[2]  = data_trained2;
  assign data_trained[3]  = data_trained3;
  assign data_trained[4]  = data_trained4;
  assign data_trained[5]  = data_trained5;
  assign data_trained[6]  = data_trained6;
  assign data_trained[7]  = data_trained7;
  assign data_trained[8]  = data_trained8;
  assign data_trained[9]  = data_trained9;
  assign data_trained[10] = data_trained10;
  assign data_trained[11] = data_trained11;
  assign data_trained[12] = data_trained12;
  assign data_trained[13] = data_trained13;
  assign data_trained[14] = data_trained14;
  assign data_trained[15] = data_trained15;

  assign datapar_out0 = lane_out[0];
  assign datapar_out1 = lane_out[1];
  assign datapar_out2 = lane_out[2];
  assign datapar_out3 = lane_out[3];
  assign datapar_out4 = lane_out[4];
  assign datapar_out5 = lane_out[5];
  assign datapar_out6 = lane_out[6];
  assign datapar_out7 = lane_out[7];

  // Phase state register
  always_ff @(posedge clk_rxg or negedge rst_rx_n) begin
    if (!rst_rx_n) begin
      phase_q <= PH_CAPTURE;
    end else begin
      phase_q <= phase_d;
    end
  end

  // Line-valid alone drives the phase; every line restarts with a capture
  always_comb begin
    phase_d = PH_CAPTURE;
    if (lvals_map) begin
      phase_d = (phase_q == PH_CAPTURE) ? PH_REPLAY : PH_CAPTURE;
    end
  end

  always_ff @(posedge clk_rxg or negedge rst_rx_n) begin
    if (!rst_rx_n) begin
      fvals <= 1'b0;
      lvals <= 1'b0;
    end else begin
      fvals <= fvals_map;
      lvals <= lvals_map;
    end
  end

  for (genvar k = 0; k < LANE_NUM; k++) begin : g_lane
    assign lane_pair[k].even = data_trained[2*k];
    assign lane_pair[k].odd  = data_trained[2*k+1];

    mapping_lane u_lane (
      .clk_rxg     (clk_rxg),
      .rst_rx_n    (rst_rx_n),
      .lvals_map   (lvals_map),
      .phase       (phase_q),
      .pair        (lane_pair[k]),
      .datapar_out (lane_out[k])
    );
  end

endmodule

// File: tb/tb_mapping_ctrl.sv
// Randomized self-checking bench for mapping_ctrl against a line-position reference model.
module tb_mapping_ctrl;

  logic              clk_rxg = 1'b0;
  logic              rst_rx_n;
  logic [15:0][11:0] din;
  logic              fvals_map;
  logic              lvals_map;
  logic [7:0][11:0]  dout;
  logic              fvals;
  logic              lvals;

  int nvec = 0;
  int nerr = 0;
  bit cmp_en = 1'b0;

  // Reference model state: position within the current input line
  int        pos = 0;
  logic [11:0] exp_d [8];
  logic [11:0] mhold [8];
  logic      exp_lv = 1'b0;
  logic      exp_fv = 1'b0;

  always #5 clk_rxg = ~clk_rxg;

  mapping_ctrl dut (
    .clk_rxg        (clk_rxg),
    .rst_rx_n       (rst_rx_n),
    .data_trained0  (din[0]),
    .data_trained1  (din[1]),
    .data_trained2  (din[2]),
    .data_trained3  (din[3]),
    .data_trained4  (din[4]),
    .data_trained5  (din[5]),
    .data_trained6  (din[6]),
    .data_trained7  (din[7]),
    .data_trained8  (din[8]),
    .data_trained9  (din[9]),
    .data_trained10 (din[10]),
    .data_trained11 (din[11]),
    .data_trained12 (din[12]),
    .data_trained13 (din[13]),
    .data_trained14 (din[14]),
    .data_trained15 (din[15]),
    .fvals_map      (fvals_map),
    .lvals_map      (lvals_map),
    .datapar_out0   (dout[0]),
    .datapar_out1   (dout[1]),
    .datapar_out2   (dout[2]),
    .datapar_out3   (dout[3]),
    .datapar_out4   (dout[4]),
    .datapar_out5   (dout[5]),
    .datapar_out6   (dout[6]),
    .datapar_out7   (dout[7]),
    .fvals          (fvals),
    .lvals          (lvals)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Even line positions show the even channels, odd positions the odd channels
  // of the group captured one cycle earlier; outside a line everything is zero.
  initial begin
    for (int k = 0; k < 8; k++) begin
      exp_d[k] = '0;
      mhold[k] = '0;
    end
  end

  always begin
    @(posedge clk_rxg or negedge rst_rx_n);
    if (!rst_rx_n) begin
      pos    = 0;
      exp_lv = 1'b0;
      exp_fv = 1'b0;
      for (int k = 0; k < 8; k++) exp_d[k] = '0;
    end else begin
      exp_lv = lvals_map;
      exp_fv = fvals_map;
      if (lvals_map) begin
        for (int k = 0; k < 8; k++) begin
          if (pos % 2 == 0) begin
            exp_d[k] = din[2*k];
            mhold[k] = din[2*k+1];
          end else begin
            exp_d[k] = mhold[k];
          end
        end
        pos++;
      end else begin
        pos = 0;
        for (int k = 0; k < 8; k++) exp_d[k] = '0;
      end
    end
  end

  // Cycle-by-cycle comparison on the falling edge
  always begin
    @(negedge clk_rxg);
    if (cmp_en) begin
      for (int k = 0; k < 8; k++) check($sformatf("model_lane%0d", k), 32'(dout[k]), 32'(exp_d[k]));
      check("model_lvals", 32'(lvals), 32'(exp_lv));
      check("model_fvals", 32'(fvals), 32'(exp_fv));
    end
  end

  task automatic rand_group();
    for (int n = 0; n < 16; n++) din[n] = 12'($urandom);
  endtask

  task automatic check_zero(input string nm);
    for (int k = 0; k < 8; k++) check($sformatf("%s_lane%0d", nm, k), 32'(dout[k]), 32'd0);
    check({nm, "_lvals"}, 32'(lvals), 32'd0);
    check({nm, "_fvals"}, 32'(fvals), 32'd0);
  endtask

  logic [15:0][11:0] saved;
  int cnt;
  int len;
  int gap;

  initial begin
    rst_rx_n  = 1'b0;
    lvals_map = 1'b1;
    fvals_map = 1'b1;
    rand_group();

    // Reset held for 100 ns with live inputs
    repeat (10) @(negedge clk_rxg);
    cmp_en = 1'b1;
    #1 check_zero("reset_hold");
    lvals_map = 1'b0;
    fvals_map = 1'b0;
    rst_rx_n  = 1'b1;
    repeat (3) @(negedge clk_rxg);
    #1 check_zero("reset_release");

    // Constant even=1 / odd=2 line of 128 cycles
    for (int n = 0; n < 16; n++) din[n] = (n % 2 == 0) ? 12'd1 : 12'd2;
    lvals_map = 1'b1;
    for (int i = 0; i < 128; i++) begin
      @(negedge clk_rxg);
      #1;
      check("pat12_lane3", 32'(dout[3]), (i % 2 == 0) ? 32'd1 : 32'd2);
      check("pat12_lvals", 32'(lvals), 32'd1);
    end
    lvals_map = 1'b0;
    @(negedge clk_rxg);
    #1 check("pat12_end_lvals", 32'(lvals), 32'd0);
    check("pat12_end_lane0", 32'(dout[0]), 32'd0);

    // Distinct words: channel n of group g carries n+16g
    lvals_map = 1'b1;
    for (int g = 0; g < 8; g++) begin
      for (int n = 0; n < 16; n++) din[n] = 12'(n + 16 * g);
      for (int p = 0; p < 2; p++) begin
        @(negedge clk_rxg);
        #1;
        for (int k = 0; k < 8; k++)
          check($sformatf("distinct_g%0d_lane%0d", g, k), 32'(dout[k]), 32'(2 * k + p + 16 * g));
      end
    end
    lvals_map = 1'b0;
    @(negedge clk_rxg);

    // Odd-length line of 129 cycles, single-cycle gap, then a new line
    cnt = 0;
    lvals_map = 1'b1;
    for (int i = 0; i < 129; i++) begin
      if (i % 2 == 0) begin
        rand_group();
        saved = din;
      end
      @(negedge clk_rxg);
      #1;
      if (lvals) cnt++;
    end
    check("odd_last_even", 32'(dout[5]), 32'(saved[10]));
    check("odd_valid_count", 32'(cnt), 32'd129);
    lvals_map = 1'b0;
    @(negedge clk_rxg);
    #1 check("odd_gap_lvals", 32'(lvals), 32'd0);
    lvals_map = 1'b1;
    rand_group();
    saved = din;
    @(negedge clk_rxg);
    #1 check("odd_next_first", 32'(dout[0]), 32'(saved[0]));
    @(negedge clk_rxg);
    #1 check("odd_next_second", 32'(dout[0]), 32'(saved[1]));
    lvals_map = 1'b0;
    @(negedge clk_rxg);

    // Frame valid follows one cycle later regardless of line valid
    fvals_map = 1'b1;
    @(negedge clk_rxg);
    #1 check("fval_rise", 32'(fvals), 32'd1);
    check("fval_rise_lvals", 32'(lvals), 32'd0);
    fvals_map = 1'b0;
    @(negedge clk_rxg);
    #1 check("fval_fall", 32'(fvals), 32'd0);

    // Randomized lines, gaps, frame valid, and occasionally unheld inputs
    for (int l = 0; l < 80; l++) begin
      len = $urandom_range(1, 40);
      gap = $urandom_range(1, 4);
      lvals_map = 1'b1;
      for (int i = 0; i < len; i++) begin
        if (i % 2 == 0 || $urandom_range(0, 7) == 0) rand_group();
        if ($urandom_range(0, 15) == 0) fvals_map = ~fvals_map;
        @(negedge clk_rxg);
      end
      lvals_map = 1'b0;
      for (int i = 0; i < gap; i++) begin
        rand_group();
        if ($urandom_range(0, 3) == 0) fvals_map = ~fvals_map;
        @(negedge clk_rxg);
      end
    end

    // Asynchronous reset during a replay cycle
    fvals_map = 1'b1;
    lvals_map = 1'b1;
    rand_group();
    @(posedge clk_rxg);
    #2 rst_rx_n = 1'b0;
    #1 check_zero("async_rst");
    @(negedge clk_rxg);
    @(negedge clk_rxg);
    rst_rx_n = 1'b1;
    rand_group();
    saved = din;
    @(negedge clk_rxg);
    #1;
    for (int k = 0; k < 8; k++)
      check($sformatf("post_rst_capture_lane%0d", k), 32'(dout[k]), 32'(saved[2*k]));
    check("post_rst_lvals", 32'(lvals), 32'd1);
    @(negedge clk_rxg);
    #1 check("post_rst_replay_lane7", 32'(dout[7]), 32'(saved[15]));
    lvals_map = 1'b0;
    repeat (3) @(negedge clk_rxg);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
